// File: rtl/bank_rr_arbiter.sv
// Per-bank request arbiter for the polynomial-memory crossbar (round-robin or fixed priority).
// Latency: req_ready is combinational in the request cycle; bank_valid/bank_sel/stall register one cycle later.
// Backpressure: losing ports see req_ready=0 and must hold req_valid/req_bank until granted.
module bank_rr_arbiter #(
    parameter int NPORT   = 4,
    parameter int NBANK   = 4,
    parameter int RR_MODE = 1,
    parameter int CNT_W   = 16,
    parameter int BW      = $clog2(NBANK),
    parameter int PW      = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [NPORT-1:0]       req_valid,
    input  logic [NPORT*BW-1:0]    req_bank,
    output logic [NPORT-1:0]       req_ready,
    output logic [NBANK-1:0]       bank_valid,
    output logic [NBANK*PW-1:0]    bank_sel,
    output logic                   stall,
    output logic [CNT_W-1:0]       conflict_cnt
);

    // Per-bank round-robin pointer: the port index that gets first look next time.
    logic [PW-1:0]    ptr     [NBANK];
    logic [NPORT-1:0] cand    [NBANK];
    logic [NBANK-1:0] win_vld;
    logic [PW-1:0]    win_idx [NBANK];
    logic [PW:0]      scan_sum;
    logic [PW-1:0]    scan_p;
    logic             refused;

    // Candidate matrix: which valid ports target each bank.
    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            for (int p = 0; p < NPORT; p++) begin
                cand[b][p] = req_valid[p] && (req_bank[p*BW +: BW] == BW'(b));
            end
        end
    end

    // Per-bank scan starting at ptr[b]; in fixed-priority mode ptr stays 0 so the
    // scan naturally picks the lowest candidate index. One extra bit on the sum
    // lets the wrap work for port counts that are not a power of two.
    always_comb begin
        scan_sum = '0;
        scan_p   = '0;
        for (int b = 0; b < NBANK; b++) begin
            win_vld[b] = 1'b0;
            win_idx[b] = '0;
            for (int k = 0; k < NPORT; k++) begin
                scan_sum = {1'b0, ptr[b]} + (PW+1)'(k);
                if (scan_sum >= (PW+1)'(NPORT)) begin
                    scan_sum = scan_sum - (PW+1)'(NPORT);
                end
                scan_p = scan_sum[PW-1:0];
                if (!win_vld[b] && cand[b][scan_p]) begin
                    win_vld[b] = 1'b1;
                    win_idx[b] = scan_p;
                end
            end
        end
    end

    // A port is ready only when it is the winner of the bank it names.
    always_comb begin
        req_ready = '0;
        for (int b = 0; b < NBANK; b++) begin
            for (int p = 0; p < NPORT; p++) begin
                if (win_vld[b] && (win_idx[b] == PW'(p))) begin
                    req_ready[p] = 1'b1;
                end
            end
        end
    end

    assign refused = |(req_valid & ~req_ready);

    // Pointer advance past the granted port; clear wins, and fixed mode pins pointers to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++) begin
                ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (clr || (RR_MODE == 0)) begin
                    ptr[b] <= '0;
                end else if (win_vld[b]) begin
                    ptr[b] <= (win_idx[b] == PW'(NPORT-1)) ? '0 : win_idx[b] + PW'(1);
                end
            end
        end
    end

    // Registered crossbar selects and stall flag, reflecting this cycle's arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_valid <= '0;
            bank_sel   <= '0;
            stall      <= 1'b0;
        end else begin
            bank_valid <= win_vld;
            for (int b = 0; b < NBANK; b++) begin
                bank_sel[b*PW +: PW] <= win_idx[b];
            end
            stall <= refused;
        end
    end

    // Saturating refusal counter; a clear in the same cycle overrides the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (clr) begin
            conflict_cnt <= '0;
        end else if (refused && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bank_rr_arbiter.sv
// Bench for bank_rr_arbiter: round-robin instance (CNT_W=2) and fixed-priority instance
// driven with identical stimulus, both compared each cycle against a behavioural model.
// Directed scenarios first, then randomized held-request traffic, then async reset mid-burst.
module tb_bank_rr_arbiter;
    localparam int NP = 4;
    localparam int NB = 4;
    localparam int BW = 2;
    localparam int PW = 2;
    localparam int MAX_R = 3;
    localparam int MAX_F = 65535;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic [NP-1:0]    req_valid = '0;
    logic [NP*BW-1:0] req_bank = '0;

    logic [NP-1:0]    ready_rr, ready_fp;
    logic [NB-1:0]    bv_rr, bv_fp;
    logic [NB*PW-1:0] sel_rr, sel_fp;
    logic             stall_rr, stall_fp;
    logic [1:0]       cnt_rr;
    logic [15:0]      cnt_fp;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state: round-robin pointers and both counters.
    int ptr_m [NB];
    int cnt_r = 0;
    int cnt_f = 0;
    logic [NP-1:0] last_rdy, last_rdy_fp;

    always #5 clk = ~clk;

    bank_rr_arbiter #(.NPORT(NP), .NBANK(NB), .RR_MODE(1), .CNT_W(2)) dut_rr (
        .clk(clk), .rst(rst), .clr(clr),
        .req_valid(req_valid), .req_bank(req_bank), .req_ready(ready_rr),
        .bank_valid(bv_rr), .bank_sel(sel_rr), .stall(stall_rr), .conflict_cnt(cnt_rr)
    );

    bank_rr_arbiter #(.NPORT(NP), .NBANK(NB), .RR_MODE(0), .CNT_W(16)) dut_fp (
        .clk(clk), .rst(rst), .clr(clr),
        .req_valid(req_valid), .req_bank(req_bank), .req_ready(ready_fp),
        .bank_valid(bv_fp), .bank_sel(sel_fp), .stall(stall_fp), .conflict_cnt(cnt_fp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NP*BW-1:0] bk4(input int a, input int b, input int c, input int d);
        return {BW'(d), BW'(c), BW'(b), BW'(a)};
    endfunction

    // Model arbitration: per bank, walk ports from the start index modulo NP and take the first requester.
    task automatic model_arb(input int rr, input logic [NP-1:0] v, input logic [NP*BW-1:0] bk,
                             output logic [NP-1:0] rdy, output logic [NB-1:0] bv,
                             output logic [NB*PW-1:0] sel);
        int start;
        int p;
        rdy = '0;
        bv  = '0;
        sel = '0;
        for (int b = 0; b < NB; b++) begin
            start = (rr != 0) ? ptr_m[b] : 0;
            for (int k = 0; k < NP; k++) begin
                p = (start + k) % NP;
                if (!bv[b] && v[p] && (int'(bk[p*BW +: BW]) == b)) begin
                    bv[b] = 1'b1;
                    sel[b*PW +: PW] = PW'(p);
                    rdy[p] = 1'b1;
                end
            end
        end
    endtask

    // One clock cycle: drive, check combinational grants, clock, check registered outputs.
    task automatic cycle(input logic [NP-1:0] v, input logic [NP*BW-1:0] bk, input logic c);
        logic [NP-1:0]    rr, rf;
        logic [NB-1:0]    bvr, bvf;
        logic [NB*PW-1:0] sr, sf;
        logic             str, stf;
        req_valid = v;
        req_bank  = bk;
        clr       = c;
        #2;
        model_arb(1, v, bk, rr, bvr, sr);
        model_arb(0, v, bk, rf, bvf, sf);
        chk("ready_rr", 32'(ready_rr), 32'(rr));
        chk("ready_fp", 32'(ready_fp), 32'(rf));
        last_rdy    = ready_rr;
        last_rdy_fp = ready_fp;
        @(posedge clk);
        str = |(v & ~rr);
        stf = |(v & ~rf);
        for (int b = 0; b < NB; b++) begin
            if (c) ptr_m[b] = 0;
            else if (bvr[b]) ptr_m[b] = (int'(sr[b*PW +: PW]) + 1) % NP;
        end
        if (c) cnt_r = 0; else if (str && cnt_r < MAX_R) cnt_r++;
        if (c) cnt_f = 0; else if (stf && cnt_f < MAX_F) cnt_f++;
        #1;
        clr = 1'b0;
        chk("bv_rr", 32'(bv_rr), 32'(bvr));
        chk("sel_rr", 32'(sel_rr), 32'(sr));
        chk("stall_rr", 32'(stall_rr), 32'(str));
        chk("cnt_rr", 32'(cnt_rr), 32'(cnt_r));
        chk("bv_fp", 32'(bv_fp), 32'(bvf));
        chk("sel_fp", 32'(sel_fp), 32'(sf));
        chk("stall_fp", 32'(stall_fp), 32'(stf));
        chk("cnt_fp", 32'(cnt_fp), 32'(cnt_f));
    endtask

    task automatic reset_model();
        for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        cnt_r = 0;
        cnt_f = 0;
    endtask

    initial begin
        logic [NP-1:0]    pend;
        logic [BW-1:0]    pbank [NP];
        int               wait_c [NP];
        logic [NP*BW-1:0] bk;

        reset_model();
        #12;
        chk("rst_bv", 32'(bv_rr), 32'h0);
        chk("rst_sel", 32'(sel_rr), 32'h0);
        chk("rst_stall", 32'(stall_rr), 32'h0);
        chk("rst_cnt", 32'(cnt_rr), 32'h0);
        chk("rst_ready", 32'(ready_rr), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // No conflict: ports 0..3 -> banks 2,0,3,1.
        cycle(4'b1111, bk4(2, 0, 3, 1), 1'b0);
        chk("nc_ready", 32'(last_rdy), 32'hf);
        chk("nc_bv", 32'(bv_rr), 32'hf);
        chk("nc_sel", 32'(sel_rr), 32'(8'b10_00_11_01));
        chk("nc_stall", 32'(stall_rr), 32'h0);

        // Full conflict on bank 1, granted ports drop out.
        cycle(4'b1111, bk4(1, 1, 1, 1), 1'b0);
        chk("fc_g0", 32'(last_rdy), 32'h1);
        cycle(4'b1110, bk4(1, 1, 1, 1), 1'b0);
        chk("fc_g1", 32'(last_rdy), 32'h2);
        cycle(4'b1100, bk4(1, 1, 1, 1), 1'b0);
        chk("fc_g2", 32'(last_rdy), 32'h4);
        cycle(4'b1000, bk4(1, 1, 1, 1), 1'b0);
        chk("fc_g3", 32'(last_rdy), 32'h8);
        chk("fc_cnt", 32'(cnt_rr), 32'h3);

        // Pointer persistence on bank 0.
        cycle(4'b0100, bk4(0, 0, 0, 0), 1'b0);
        cycle(4'b1001, bk4(0, 0, 0, 0), 1'b0);
        chk("pp_first", 32'(last_rdy), 32'h8);
        cycle(4'b0001, bk4(0, 0, 0, 0), 1'b0);
        chk("pp_second", 32'(last_rdy), 32'h1);

        // Fixed priority: ports 1 and 3 contend for bank 2 every cycle.
        for (int i = 0; i < 4; i++) begin
            cycle(4'b1010, bk4(0, 2, 0, 2), 1'b0);
            chk("fp_win", 32'(last_rdy_fp), 32'h2);
        end

        // Clear during a conflict, then pointer and saturation checks.
        cycle(4'b1111, bk4(1, 1, 1, 1), 1'b1);
        chk("clr_cnt", 32'(cnt_rr), 32'h0);
        cycle(4'b1111, bk4(3, 3, 3, 3), 1'b0);
        chk("clr_ptr", 32'(last_rdy), 32'h1);
        for (int i = 0; i < 5; i++) cycle(4'b0011, bk4(0, 0, 0, 0), 1'b0);
        chk("sat_cnt", 32'(cnt_rr), 32'h3);

        // Randomized held traffic with fairness tracking on the round-robin instance.
        pend = '0;
        for (int p = 0; p < NP; p++) begin
            wait_c[p] = 0;
            pbank[p]  = '0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && $urandom_range(0, 9) < 7) begin
                    pend[p]   = 1'b1;
                    pbank[p]  = BW'($urandom_range(0, NB-1));
                    wait_c[p] = 0;
                end
                bk[p*BW +: BW] = pbank[p];
            end
            cycle(pend, bk, 1'b0);
            for (int p = 0; p < NP; p++) begin
                if (pend[p]) begin
                    if (last_rdy[p]) begin
                        chk("fair", 32'(wait_c[p] < NP), 32'h1);
                        pend[p] = 1'b0;
                    end else begin
                        wait_c[p]++;
                    end
                end
            end
        end

        // Async reset asserted between edges during a 4-way conflict.
        cycle(4'b1111, bk4(2, 2, 2, 2), 1'b0);
        cycle(4'b1110, bk4(2, 2, 2, 2), 1'b0);
        req_valid = 4'b1111;
        #3 rst = 1'b1;
        #1;
        chk("arst_bv", 32'(bv_rr), 32'h0);
        chk("arst_stall", 32'(stall_rr), 32'h0);
        chk("arst_cnt", 32'(cnt_rr), 32'h0);
        chk("arst_cnt_fp", 32'(cnt_fp), 32'h0);
        reset_model();
        @(posedge clk);
        #1;
        chk("arst_hold_bv", 32'(bv_rr), 32'h0);
        rst = 1'b0;
        cycle(4'b1111, bk4(2, 2, 2, 2), 1'b0);
        chk("arst_first", 32'(last_rdy), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/bank_rr_arbiter.md
# bank_rr_arbiter

Parametrised per-bank request arbiter for the Kyber polynomial-memory crossbar. NPORT requesters each present a target bank index; the block resolves bank conflicts with a per-bank round-robin (or legacy fixed-priority) policy, back-pressures losing ports through a ready handshake, and drives registered crossbar select lines to the NBANK memory banks. It sits between the NTT/PWM address generators and the bank-side read/write muxes, and replaces the purely combinational 4x4 select decode.

## Interface
- NPORT, 4: number of requesting ports; range 2..16.
- NBANK, 4: number of memory banks; power of two, range 2..16.
- RR_MODE, 1: 1 = round-robin per bank; 0 = fixed priority, where the lowest port index wins.
- CNT_W, 16: width of the saturating conflict counter.
- BW, log2(NBANK): bank index width (derived).
- PW, max(1, clog2(NPORT)): port index width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of the pointers and the conflict counter.
- req_valid  in  NPORT  per-port request valid.
- req_bank  in  NPORT*BW  per-port target bank; port p occupies bits [p*BW +: BW].
- req_ready  out  NPORT  per-port grant (combinational, same cycle).
- bank_valid  out  NBANK  registered: bank b is driven this cycle.
- bank_sel  out  NBANK*PW  registered: granted port index for bank b, in bits [b*PW +: PW].
- stall  out  1  registered: at least one valid request was refused in the previous cycle.
- conflict_cnt  out  CNT_W  saturating count of cycles with at least one refusal.

## Operation
- Per bank b, the candidate set is {p : req_valid[p] && req_bank[p]==b}.
- RR_MODE=1: the winner is the first candidate found scanning p = ptr[b], ptr[b]+1, … mod NPORT.
- RR_MODE=0: the winner is the lowest-index candidate; ptr is unused and held at 0.
- req_ready[p]=1 iff port p is the winner of its target bank. Otherwise req_ready[p]=0, including when req_valid[p]=0.
- A request is transferred when req_valid && req_ready. A refused port must hold req_valid and req_bank stable until it is accepted.
- Pointer update (RR_MODE=1): when bank b grants port p, ptr[b] ← (p+1) mod NPORT. A bank with no candidates keeps its pointer.
- Registered outputs, updated each cycle from that cycle's arbitration:
  - bank_valid[b] ← bank b had a winner;
  - bank_sel[b] ← winner index, or 0 if there is none;
  - stall ← any refused valid request.
- conflict_cnt increments by 1 in every cycle with at least one refusal, and saturates at 2^CNT_W−1 with no wrap.
- clr=1: all ptr ← 0 and conflict_cnt ← 0. Arbitration in that cycle still proceeds using the pre-clear pointers, and the registered outputs update normally.
- Invariants:
  - at most one grant per bank per cycle;
  - each port is granted at most once (it names exactly one bank);
  - with no conflicts, every valid request is granted in the same cycle.

## Timing
- Reset values: bank_valid=0, bank_sel=0, stall=0, conflict_cnt=0, all ptr=0. req_ready is combinational and is 0 whenever req_valid=0.
- Latency: req_ready is valid in the same cycle as the request (combinational path from req_valid, req_bank and ptr). bank_valid and bank_sel follow one cycle later (cycle t+1).
- Fairness bound (RR_MODE=1): a held request to bank b is granted within NPORT cycles.
- Reset asserted mid-operation: all state clears immediately. No grant issued in the reset cycle produces a bank_valid.
- Simultaneous clr and conflict: the counter reads 0 after the edge, i.e. clr wins over the increment.
- Saturation: at conflict_cnt = max, further refusal cycles leave it unchanged.

## Test plan
- No conflict: NPORT=NBANK=4, ports 0..3 request banks 2,0,3,1 → req_ready=4'b1111. Next cycle: bank_valid=4'b1111, bank_sel={b0:1, b1:3, b2:0, b3:2}, stall=0.
- Full conflict, RR_MODE=1: all four ports hold requests to bank 1 → grants in order 0,1,2,3 on consecutive cycles, one per cycle. stall=1 for the first three registered cycles; conflict_cnt reaches 3.
- Pointer persistence: port 2 is granted bank 0; ports 0 and 3 then request bank 0 → port 3 wins first (ptr=3), then port 0.
- Fixed priority, RR_MODE=0: ports 1 and 3 request bank 2 repeatedly and are re-asserted after each grant → port 1 wins every cycle and port 3 is never granted.
- Saturation and clear: CNT_W=2 with 5 conflict cycles → conflict_cnt=3. Pulsing clr during a conflict cycle → conflict_cnt=0 and ptr=0 next cycle.
- Async reset mid-burst: assert rst between clock edges during a 4-way conflict → bank_valid, stall and conflict_cnt read 0 immediately. After release, the port-0 grant comes first.
